// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request at a time, feeding the fetch/decode register.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_unit #(
  parameter int unsigned           REG_WIDTH = 32,
  parameter logic [REG_WIDTH-1:0]  RESET_PC  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 imem_req_o,
  output logic [REG_WIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [REG_WIDTH-1:0] imem_rdata_i,
  input  logic                 redirect_i,
  input  logic [REG_WIDTH-1:0] redirect_pc_i,
  input  logic                 stall_i,
  output logic                 inst_valid_o,
  output logic [REG_WIDTH-1:0] inst_o,
  output logic [REG_WIDTH-1:0] pc_o,
  output logic [REG_WIDTH-1:0] pc_plus4_o,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic                 misalign_o,
`endif
  output logic [6:0]           op_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t               state_q;
  logic [REG_WIDTH-1:0] pc_q;
  logic [REG_WIDTH-1:0] pc_pend_q;
  logic [REG_WIDTH-1:0] redir_pc;
  logic                 discard_q;
  logic                 slot_free;
  logic                 fire;
  logic                 outstanding;
  logic                 resp;
  logic                 drop_next;
`ifdef FETCH_MISALIGN_CHK_EN
  logic                 halt_q;
  logic                 misaligned;

  assign misaligned = (redirect_pc_i[1:0] != 2'b00);
`endif

  assign slot_free   = !inst_valid_o || !stall_i;
  assign imem_req_o  = (state_q == REQ) && slot_free;
  assign imem_addr_o = pc_q;
  assign fire        = imem_req_o && imem_gnt_i;
  // A response is still owed to us while waiting, or while a flushed request is in flight.
  assign outstanding = (state_q == WAIT) || discard_q;
  assign resp        = imem_rvalid_i && outstanding;
  assign drop_next   = (outstanding && !imem_rvalid_i) || fire;
  assign redir_pc    = redirect_pc_i & ~(REG_WIDTH'(3));
  assign pc_plus4_o  = pc_o + REG_WIDTH'(4);
  assign op_o        = inst_o[6:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pc_pend_q    <= '0;
      discard_q    <= 1'b0;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      pc_o         <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      halt_q       <= 1'b0;
      misalign_o   <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_o <= 1'b0;
`endif
      if (redirect_i) begin
        // Redirect wins over everything; an in-flight or just-granted request must be dropped.
        pc_q         <= redir_pc;
        inst_valid_o <= 1'b0;
        discard_q    <= drop_next;
        state_q      <= drop_next ? WAIT : REQ;
`ifdef FETCH_MISALIGN_CHK_EN
        halt_q <= misaligned;
        if (misaligned) begin
          misalign_o <= 1'b1;
          state_q    <= IDLE;
        end
`endif
      end else begin
        if (inst_valid_o && !stall_i)
          inst_valid_o <= 1'b0;
        if (fire) begin
          pc_q      <= pc_q + REG_WIDTH'(4);
          pc_pend_q <= pc_q;
        end
        if (resp) begin
          if (discard_q) begin
            discard_q <= 1'b0;
          end else begin
            inst_o       <= imem_rdata_i;
            pc_o         <= pc_pend_q;
            inst_valid_o <= 1'b1;
          end
        end
        case (state_q)
          IDLE: begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (!halt_q)
              state_q <= REQ;
`else
            state_q <= REQ;
`endif
          end
          REQ:  if (fire) state_q <= WAIT;
          WAIT: if (imem_rvalid_i) state_q <= (discard_q || !stall_i) ? REQ : HOLD;
          HOLD: if (slot_free) state_q <= REQ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small memory model answers requests and a monitor scores outputs.
// Build with FETCH_MISALIGN_CHK_EN defined to cover the misaligned-redirect halt.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'hDEAD_BEEF;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        stall_i = 1'b0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [6:0]  op_o;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  bit          gnt_block = 1'b0;
  int          rv_delay = 1;
  int          rv_cnt = 0;
  logic [31:0] mem_addr = '0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  int          pops = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.REG_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
`ifdef FETCH_MISALIGN_CHK_EN
    .misalign_o    (misalign_o),
`endif
    .op_o          (op_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Inputs change on the falling edge; checks run 3ns later once memory and monitor have settled.
  task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    stall_i       = stall;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #3;
  endtask

  // Memory model: grants whatever is requested unless blocked, answers rv_delay cycles later with addr|0x13.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_addr | 32'h13;
        end
      end
      imem_gnt_i = imem_req_o && !gnt_block;
      if (imem_gnt_i) begin
        mem_addr = imem_addr_o;
        rv_cnt   = rv_delay;
      end
    end
  end

  // Monitor: every output transfer (valid and not stalled) pops one expected PC.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && inst_valid_o && !stall_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got pc %h, expected no output", pc_o);
        end else begin
          exp_pc   = exp_q.pop_front();
          exp_inst = exp_pc | 32'h13;
          pops++;
          checkOutput("out_pc", pc_o, exp_pc);
          checkOutput("out_inst", inst_o, exp_inst);
          checkOutput("out_pc_plus4", pc_plus4_o, exp_pc + 32'd4);
          checkOutput("out_op", {25'd0, op_o}, {25'd0, exp_inst[6:0]});
        end
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 20000ns");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    @(negedge clk);
    #3;
    checkOutput("rst_req", {31'd0, imem_req_o}, 32'd0);
    checkOutput("rst_addr", imem_addr_o, 32'h0);
    checkOutput("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    checkOutput("rst_inst", inst_o, 32'h0);
    checkOutput("rst_pc", pc_o, 32'h0);
    checkOutput("rst_pc_plus4", pc_plus4_o, 32'h4);
    checkOutput("rst_op", {25'd0, op_o}, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    checkOutput("rst_misalign", {31'd0, misalign_o}, 32'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    #3;
    checkOutput("c0_idle_req", {31'd0, imem_req_o}, 32'd0);

    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    applyStimulus(0, 0, 0);
    checkOutput("c1_req", {31'd0, imem_req_o}, 32'd1);
    checkOutput("c1_addr", imem_addr_o, 32'h0);
    applyStimulus(0, 0, 0);
    checkOutput("c2_req", {31'd0, imem_req_o}, 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("c3_valid", {31'd0, inst_valid_o}, 32'd1);
    checkOutput("c3_pc", pc_o, 32'h0);
    checkOutput("c3_addr", imem_addr_o, 32'h4);
    applyStimulus(0, 0, 0);
    checkOutput("c4_req", {31'd0, imem_req_o}, 32'd0);

    gnt_block = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0);
      checkOutput("stall_req", {31'd0, imem_req_o}, 32'd0);
      checkOutput("stall_valid", {31'd0, inst_valid_o}, 32'd1);
      checkOutput("stall_pc", pc_o, 32'h4);
      checkOutput("stall_inst", inst_o, 32'h17);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0);
      checkOutput("nognt_req", {31'd0, imem_req_o}, 32'd1);
      checkOutput("nognt_addr", imem_addr_o, 32'h8);
    end
    gnt_block = 1'b0;
    applyStimulus(0, 0, 0);
    checkOutput("c12_addr", imem_addr_o, 32'h8);
    applyStimulus(0, 0, 0);
    checkOutput("c13_valid", {31'd0, inst_valid_o}, 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("c14_pc", pc_o, 32'h8);
    checkOutput("c14_addr", imem_addr_o, 32'hC);

    exp_q.push_back(32'h100);
    applyStimulus(0, 1, 32'h100);
    applyStimulus(0, 0, 0);
    checkOutput("redir_rv_valid", {31'd0, inst_valid_o}, 32'd0);
    checkOutput("redir_rv_req", {31'd0, imem_req_o}, 32'd1);
    checkOutput("redir_rv_addr", imem_addr_o, 32'h100);
    applyStimulus(0, 0, 0);
    rv_delay = 3;
    applyStimulus(0, 0, 0);
    checkOutput("c18_pc", pc_o, 32'h100);
    checkOutput("c18_addr", imem_addr_o, 32'h104);

    exp_q.push_back(32'h200);
    applyStimulus(0, 1, 32'h200);
    rv_delay = 1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0);
      checkOutput("pend_req", {31'd0, imem_req_o}, 32'd0);
      checkOutput("pend_valid", {31'd0, inst_valid_o}, 32'd0);
    end
    applyStimulus(0, 0, 0);
    checkOutput("pend_next_addr", imem_addr_o, 32'h200);
    checkOutput("pend_next_req", {31'd0, imem_req_o}, 32'd1);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("c24_pc", pc_o, 32'h200);

    applyStimulus(0, 1, 32'h102);
    applyStimulus(0, 0, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    checkOutput("mis_pulse", {31'd0, misalign_o}, 32'd1);
    checkOutput("mis_req", {31'd0, imem_req_o}, 32'd0);
`else
    checkOutput("mis_req", {31'd0, imem_req_o}, 32'd1);
    checkOutput("mis_addr", imem_addr_o, 32'h100);
`endif

    exp_q.push_back(32'hFFFF_FFFC);
    applyStimulus(0, 1, 32'hFFFF_FFFC);
`ifdef FETCH_MISALIGN_CHK_EN
    checkOutput("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
    checkOutput("mis_halt_req", {31'd0, imem_req_o}, 32'd0);
`endif
    applyStimulus(0, 0, 0);
    checkOutput("wrap_req", {31'd0, imem_req_o}, 32'd1);
    checkOutput("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0);
    gnt_block = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("wrap_pc", pc_o, 32'hFFFF_FFFC);
    checkOutput("wrap_next_addr", imem_addr_o, 32'h0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      applyStimulus(0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0);
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
    checkOutput("out_count", 32'(pops), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
